// File: rtl/uart_tx_fsm_ctrl.sv
// UART transmit sequencer: walks START, DATA, optional PARITY and STOP bit times, one state per CLK.
// Accepts a frame in the same cycle Data_Valid meets IDLE. Requests arriving mid-frame wait, because busy holds the datapath.
module uart_tx_fsm_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    output logic       ser_load,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int              CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             stop_cnt;
    logic             par_en_q;

    // Gated by RST so a held request cannot strobe the datapath during reset.
    assign ser_load = RST && Data_Valid && (state == S_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ser_load) begin
                        state    <= S_START;
                        par_en_q <= PAR_EN;
                    end
                end
                S_START: begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                end
                S_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    state    <= S_STOP;
                    stop_cnt <= 1'b0;
                end
                S_STOP: begin
                    if (stop_cnt == STOP_LAST) begin
                        state    <= S_IDLE;
                        stop_cnt <= 1'b0;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ser_en     = 1'b0;
        mux_sel    = 2'b01;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_START: begin
                mux_sel = 2'b00;
                busy    = 1'b1;
            end
            S_DATA: begin
                ser_en  = 1'b1;
                mux_sel = 2'b10;
                busy    = 1'b1;
            end
            S_PARITY: begin
                mux_sel = 2'b11;
                busy    = 1'b1;
            end
            S_STOP: begin
                busy       = 1'b1;
                frame_done = (stop_cnt == STOP_LAST);
            end
            default: begin
                mux_sel = 2'b01;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm_ctrl.sv
// Bench for uart_tx_fsm_ctrl: dut_a is 8 data bits with 1 stop bit, and dut_b is 7 data bits with 2 stop bits.
// The expected per-cycle outputs {ser_load, ser_en, mux_sel, busy, frame_done} are queued as stimulus is planned, then popped each cycle.
module tb_uart_tx_fsm_ctrl;

    localparam logic [5:0] E_ACC   = 6'b1_0_01_0_0;
    localparam logic [5:0] E_IDLE  = 6'b0_0_01_0_0;
    localparam logic [5:0] E_START = 6'b0_0_00_1_0;
    localparam logic [5:0] E_DATA  = 6'b0_1_10_1_0;
    localparam logic [5:0] E_PAR   = 6'b0_0_11_1_0;
    localparam logic [5:0] E_STOP  = 6'b0_0_01_1_0;
    localparam logic [5:0] E_LAST  = 6'b0_0_01_1_1;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       dv  = 1'b0;
    logic       pen = 1'b0;
    logic       a_ser_load, a_ser_en, a_busy, a_frame_done;
    logic       b_ser_load, b_ser_en, b_busy, b_frame_done;
    logic [1:0] a_mux_sel, b_mux_sel;
    logic [5:0] exp_q[$];
    logic [5:0] exp_v, obs;
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt;
    int         n;

    always #5 CLK = ~CLK;

    uart_tx_fsm_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(RST), .Data_Valid(dv), .PAR_EN(pen),
        .ser_load(a_ser_load), .ser_en(a_ser_en), .mux_sel(a_mux_sel),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    uart_tx_fsm_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .Data_Valid(dv), .PAR_EN(pen),
        .ser_load(b_ser_load), .ser_en(b_ser_en), .mux_sel(b_mux_sel),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    wire [5:0] a_obs = {a_ser_load, a_ser_en, a_mux_sel, a_busy, a_frame_done};
    wire [5:0] b_obs = {b_ser_load, b_ser_en, b_mux_sel, b_busy, b_frame_done};

    // Expected frame body, from START through the last STOP cycle.
    task automatic push_frame(input int dw, input int sb, input bit par);
        exp_q.push_back(E_START);
        for (int k = 0; k < dw; k++) exp_q.push_back(E_DATA);
        if (par) exp_q.push_back(E_PAR);
        for (int k = 0; k < sb; k++) exp_q.push_back((k == sb - 1) ? E_LAST : E_STOP);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        dv  = 1'b0;
        pen = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0;
        dv  = 1'b1;
        pen = 1'b1;
        #1;
        checks++;
        if (a_obs !== E_IDLE) begin errors++; $display("FAIL reset_a got=%b exp=%b", a_obs, E_IDLE); end
        checks++;
        if (b_obs !== E_IDLE) begin errors++; $display("FAIL reset_b got=%b exp=%b", b_obs, E_IDLE); end
        @(negedge CLK);
        #1;
        checks++;
        if (a_obs !== E_IDLE) begin errors++; $display("FAIL reset_hold got=%b exp=%b", a_obs, E_IDLE); end
        @(negedge CLK);
        RST = 1'b1;
        dv  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (a_obs !== E_IDLE) begin errors++; $display("FAIL reset_release c%0d got=%b exp=%b", i, a_obs, E_IDLE); end
        end
    endtask

    task automatic test_parity_frame();
        do_reset();
        exp_q.push_back(E_ACC);
        push_frame(8, 1, 1'b1);
        exp_q.push_back(E_IDLE);
        n = exp_q.size();
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i == 0);
            pen = 1'b1;
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (a_obs !== exp_v) begin errors++; $display("FAIL parity_frame c%0d got=%b exp=%b", i, a_obs, exp_v); end
            if (a_busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 11) begin errors++; $display("FAIL parity_busy_len got=%0d exp=11", busy_cnt); end
    endtask

    task automatic test_no_parity();
        do_reset();
        exp_q.push_back(E_ACC);
        push_frame(8, 1, 1'b0);
        exp_q.push_back(E_IDLE);
        n = exp_q.size();
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i == 0);
            pen = 1'b0;
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (a_obs !== exp_v) begin errors++; $display("FAIL no_parity c%0d got=%b exp=%b", i, a_obs, exp_v); end
            if (a_busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 10) begin errors++; $display("FAIL no_parity_len got=%0d exp=10", busy_cnt); end
    endtask

    task automatic test_par_toggle();
        do_reset();
        exp_q.push_back(E_ACC);
        push_frame(8, 1, 1'b1);
        exp_q.push_back(E_IDLE);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i == 0);
            pen = (i < 4);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (a_obs !== exp_v) begin errors++; $display("FAIL par_toggle c%0d got=%b exp=%b", i, a_obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(E_ACC);
            push_frame(8, 1, 1'b1);
        end
        exp_q.push_back(E_IDLE);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i < n - 1);
            pen = 1'b1;
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (a_obs !== exp_v) begin errors++; $display("FAIL back_to_back c%0d got=%b exp=%b", i, a_obs, exp_v); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        exp_q.push_back(E_ACC);
        exp_q.push_back(E_START);
        for (int k = 0; k < 4; k++) exp_q.push_back(E_DATA);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i == 0);
            pen = 1'b1;
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (a_obs !== exp_v) begin errors++; $display("FAIL mid_reset_pre c%0d got=%b exp=%b", i, a_obs, exp_v); end
        end
        // Still inside DATA cycle 4: pull reset asynchronously.
        #1;
        RST = 1'b0;
        #1;
        checks++;
        if (a_obs !== E_IDLE) begin errors++; $display("FAIL mid_reset_async got=%b exp=%b", a_obs, E_IDLE); end
        @(negedge CLK);
        RST = 1'b1;
        dv  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (a_obs !== E_IDLE) begin errors++; $display("FAIL mid_reset_idle c%0d got=%b exp=%b", i, a_obs, E_IDLE); end
        end
        // A fresh frame must run a full eight data bits, proving bit_cnt was cleared.
        exp_q.push_back(E_ACC);
        push_frame(8, 1, 1'b0);
        exp_q.push_back(E_IDLE);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i == 0);
            pen = 1'b0;
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (a_obs !== exp_v) begin errors++; $display("FAIL mid_reset_post c%0d got=%b exp=%b", i, a_obs, exp_v); end
        end
    endtask

    task automatic test_two_stop_bits();
        do_reset();
        exp_q.push_back(E_ACC);
        push_frame(7, 2, 1'b1);
        exp_q.push_back(E_IDLE);
        n = exp_q.size();
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            dv  = (i == 0);
            pen = 1'b1;
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (b_obs !== exp_v) begin errors++; $display("FAIL two_stop c%0d got=%b exp=%b", i, b_obs, exp_v); end
            if (b_busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 11) begin errors++; $display("FAIL two_stop_len got=%0d exp=11", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_parity_frame();
        test_no_parity();
        test_par_toggle();
        test_back_to_back();
        test_mid_reset();
        test_two_stop_bits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fsm_ctrl.md
UART_TX_FSM_CTRL -- requirements
Module: uart_tx_fsm_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, data bits per frame (legal range 5..9).
REQ-002 SHALL provide parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-003 SHALL have port CLK  input  1  bit-rate clock; one CLK period = one UART bit time.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Data_Valid  input  1  frame request; a byte is present on the parallel bus.
REQ-006 SHALL have port PAR_EN  input  1  parity bit inserted in the frame when 1.
REQ-007 SHALL have port ser_load  output  1  serializer/parity-capture strobe, combinational.
REQ-008 SHALL have port ser_en  output  1  serializer shift enable.
REQ-009 SHALL have port mux_sel  output  2  TX line source: 00 start(0), 01 stop/idle(1), 10 serial data, 11 parity bit.
REQ-010 SHALL have port busy  output  1  frame in progress; gates acceptance in the parity and serializer blocks.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse in the last stop-bit cycle.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP in a single state register, with outputs decoded from that register only, except ser_load.
REQ-013 SHALL assert ser_load = Data_Valid && (state == IDLE) in the same cycle; this is the only acceptance condition.
REQ-014 SHALL transition IDLE->START on the edge where ser_load = 1, and SHALL capture PAR_EN into par_en_q on that edge; PAR_EN changes mid-frame SHALL be ignored.
REQ-015 SHALL hold START for exactly 1 cycle, then enter DATA with bit_cnt = 0.
REQ-016 SHALL hold DATA for exactly DATA_WIDTH cycles, incrementing bit_cnt each cycle; on bit_cnt == DATA_WIDTH-1, SHALL go to PARITY if par_en_q = 1, else to STOP.
REQ-017 SHALL hold PARITY for exactly 1 cycle, then enter STOP.
REQ-018 SHALL hold STOP for exactly STOP_BITS cycles (stop_cnt), then return to IDLE unconditionally; a new frame SHALL NOT be accepted before IDLE.
REQ-019 SHALL assert ser_en only in DATA.
REQ-020 SHALL drive mux_sel as: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-021 SHALL drive busy = 1 in START, DATA, PARITY, and STOP, and busy = 0 in IDLE.
REQ-022 SHALL assert frame_done only in the final STOP cycle.
REQ-023 SHALL have a frame length of 1 + DATA_WIDTH + par_en_q + STOP_BITS cycles; back-to-back frames SHALL be separated by at least 1 IDLE cycle.
REQ-024 SHALL ignore Data_Valid held high throughout a frame until IDLE, then accept it as a new frame in the first IDLE cycle.
REQ-025 SHALL size bit_cnt at $clog2(DATA_WIDTH) bits; it SHALL never exceed DATA_WIDTH-1 and SHALL clear on exit from DATA.
REQ-026 SHALL force any unreachable state encoding to IDLE on the next edge.

Reset
REQ-027 SHALL, on RST low at any time including mid-frame, immediately set state = IDLE, bit_cnt = 0, stop_cnt = 0, and par_en_q = 0.
REQ-028 SHALL, while RST is low, drive outputs busy = 0, ser_en = 0, mux_sel = 01, frame_done = 0, and ser_load = 0.
REQ-029 SHALL make no frame acceptance on the first CLK edge after RST deasserts unless Data_Valid = 1 in IDLE on that edge.

Verification
REQ-030 Verification SHALL cover: DATA_WIDTH = 8, STOP_BITS = 1, PAR_EN = 1, single Data_Valid pulse -> mux_sel sequence 00, 10x8, 11, 01; busy high 11 cycles; frame_done on cycle 11; ser_en high cycles 2..9.
REQ-031 Verification SHALL cover: PAR_EN = 0 -> no 11 on mux_sel; frame = 10 cycles; STOP follows the 8th DATA cycle directly.
REQ-032 Verification SHALL cover: PAR_EN toggled 1->0 during DATA -> parity cycle still present (par_en_q captured at accept).
REQ-033 Verification SHALL cover: Data_Valid held high continuously -> frames repeat with exactly 1 IDLE cycle (mux_sel 01, busy 0, ser_load 1) between them.
REQ-034 Verification SHALL cover: RST pulsed low during DATA cycle 4 -> outputs immediately at reset values; after release with Data_Valid = 0, remains IDLE.
REQ-035 Verification SHALL cover: STOP_BITS = 2, DATA_WIDTH = 7, PAR_EN = 1 -> frame = 11 cycles, two STOP cycles, frame_done only in the second.
